// File: rtl/crc8_stream_appender.sv
// CRC-8 (poly 0x07, MSB-first) stream appender: passes data bytes through a
// one-entry output register and appends the frame CRC as the final beat.
module crc8_stream_appender #(
    parameter logic [7:0] INIT    = 8'h00,
    parameter logic [7:0] XOR_OUT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        abort,
    output logic [7:0]  crc_value,
    output logic [15:0] frame_count
);

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic       slot_free;
    logic       in_fire;
    logic       out_fire;
    logic [7:0] crc_upd;

    // Same equations as the combinational byte-CRC stage.
    function automatic logic [7:0] crc8_next(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] d;
        logic [7:0] n;
        d    = crc ^ data;
        n[0] = d[0] ^ d[6] ^ d[7];
        n[1] = d[0] ^ d[1] ^ d[6];
        n[2] = d[0] ^ d[1] ^ d[2] ^ d[6];
        n[3] = d[1] ^ d[2] ^ d[3] ^ d[7];
        n[4] = d[2] ^ d[3] ^ d[4];
        n[5] = d[3] ^ d[4] ^ d[5];
        n[6] = d[4] ^ d[5] ^ d[6];
        n[7] = d[5] ^ d[6] ^ d[7];
        return n;
    endfunction

    always_comb begin
        slot_free = !m_valid_q || m_ready;
        s_ready   = (state_q == PASS) && slot_free && !abort;
        in_fire   = s_valid && s_ready;
        out_fire  = m_valid_q && m_ready;
        crc_upd   = crc8_next(crc_q, s_data);
    end

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        frame_count_d = frame_count_q;

        if (out_fire && m_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end

        if (out_fire) begin
            m_valid_d = 1'b0;
        end

        // Abort only drops CRC state; the beat already in the slot drains.
        if (abort) begin
            state_d = PASS;
            crc_d   = INIT;
        end else begin
            unique case (state_q)
                PASS: begin
                    if (in_fire) begin
                        m_data_d  = s_data;
                        m_last_d  = 1'b0;
                        m_valid_d = 1'b1;
                        crc_d     = crc_upd;
                        if (s_last) begin
                            state_d = APPEND;
                        end
                    end
                end
                APPEND: begin
                    if (slot_free) begin
                        m_data_d  = crc_q ^ XOR_OUT;
                        m_last_d  = 1'b1;
                        m_valid_d = 1'b1;
                        crc_d     = INIT;
                        state_d   = PASS;
                    end
                end
                default: begin
                    state_d = PASS;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PASS;
            crc_q         <= INIT;
            m_valid_q     <= 1'b0;
            m_data_q      <= 8'h00;
            m_last_q      <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign crc_value   = crc_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_crc8_stream_appender.sv
// Directed bench for crc8_stream_appender with hand-computed CRC beats.
module tb_crc8_stream_appender;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        abort;
    logic [7:0]  crc_value;
    logic [15:0] frame_count;

    logic        s2_valid;
    logic        s2_ready;
    logic [7:0]  s2_data;
    logic        s2_last;
    logic        m2_valid;
    logic [7:0]  m2_data;
    logic        m2_last;
    logic [7:0]  crc2_value;
    logic [15:0] frame2_count;

    int checks = 0;
    int errors = 0;

    int         rdy_mode = 0;
    int         rdy_idx  = 0;
    logic [8:0] obs[$];
    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;

    crc8_stream_appender #(.INIT(8'h00), .XOR_OUT(8'h00)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .abort(abort), .crc_value(crc_value),
        .frame_count(frame_count)
    );

    crc8_stream_appender #(.INIT(8'h00), .XOR_OUT(8'h55)) dut2 (
        .clk(clk), .rst(rst),
        .s_valid(s2_valid), .s_ready(s2_ready),
        .s_data(s2_data), .s_last(s2_last),
        .m_valid(m2_valid), .m_ready(1'b1),
        .m_data(m2_data), .m_last(m2_last),
        .abort(1'b0), .crc_value(crc2_value),
        .frame_count(frame2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // m_ready: 0 = held high, 1 = 1,0,0,1 pattern, 2 = held low
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            m_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            rdy_idx++;
        end else begin
            m_ready = (rdy_mode == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {23'd0, m_valid, m_last, m_data},
                      {23'd0, 1'b1, prev_beat});
            if (m_valid && m_ready)
                obs.push_back({m_last, m_data});
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit fired = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int n = 0; n < 200 && !fired; n++) begin
            @(negedge clk);
            fired = s_ready;
            @(posedge clk);
            #1;
        end
        if (!fired) check("send_timeout", 0, 1);
        s_valid = 1'b0;
        s_data  = 8'hA5;
        s_last  = 1'b0;
    endtask

    task automatic expect_beats(input string tag);
        int n = 0;
        while (obs.size() < exp_q.size() && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), {23'd0, obs[i]},
                  {23'd0, exp_q[i]});
        obs.delete();
        exp_q.delete();
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        abort    = 1'b0;
        m_ready  = 1'b1;
        s2_valid = 1'b0;
        s2_data  = 8'h00;
        s2_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_m_data", {24'd0, m_data}, 0);
        check("rst_m_last", {31'd0, m_last}, 0);
        check("rst_crc", {24'd0, crc_value}, 0);
        check("rst_fc", {16'd0, frame_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "123456789" with m_ready high
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h31 + 8'(i), i == 8);
            exp_q.push_back({1'b0, 8'h31 + 8'(i)});
        end
        exp_q.push_back({1'b1, 8'hF4});
        expect_beats("ascii");
        check("ascii_fc", {16'd0, frame_count}, 1);
        check("ascii_crc", {24'd0, crc_value}, 0);

        // back-to-back single-byte frames
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        check("gap1_low", {31'd0, s_ready}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("gap1_high", {31'd0, s_ready}, 1);
        @(posedge clk); #1;
        send_byte(8'hFF, 1'b1);
        @(negedge clk);
        check("gap2_low", {31'd0, s_ready}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("gap2_high", {31'd0, s_ready}, 1);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h07});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'hF3});
        expect_beats("single");
        check("single_fc", {16'd0, frame_count}, 3);
        check("single_crc", {24'd0, crc_value}, 0);

        // same ASCII frame with m_ready toggling 1,0,0,1
        rdy_idx  = 0;
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h31 + 8'(i), i == 8);
            exp_q.push_back({1'b0, 8'h31 + 8'(i)});
        end
        exp_q.push_back({1'b1, 8'hF4});
        expect_beats("stall");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_fc", {16'd0, frame_count}, 4);

        // abort mid-frame, then frame "1"
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        check("abort_sready", {31'd0, s_ready}, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_crc", {24'd0, crc_value}, 0);
        send_byte(8'h31, 1'b1);
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h32});
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b1, 8'h97});
        expect_beats("abort");
        check("abort_fc", {16'd0, frame_count}, 5);

        // reset while a beat is stalled in the slot
        rdy_mode = 2;
        @(posedge clk); #1;
        send_byte(8'h31, 1'b0);
        check("pre_rst_valid", {31'd0, m_valid}, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, m_valid}, 0);
        check("mid_rst_crc", {24'd0, crc_value}, 0);
        check("mid_rst_fc", {16'd0, frame_count}, 0);
        @(negedge clk);
        rst      = 1'b0;
        rdy_mode = 0;
        obs.delete();
        @(posedge clk); #1;
        send_byte(8'h01, 1'b1);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h07});
        expect_beats("post_rst");
        check("post_rst_fc", {16'd0, frame_count}, 1);

        // XOR_OUT = 0x55 instance
        s2_valid = 1'b1;
        s2_data  = 8'h01;
        s2_last  = 1'b1;
        @(negedge clk);
        check("x55_sready", {31'd0, s2_ready}, 1);
        @(posedge clk); #1;
        s2_valid = 1'b0;
        @(negedge clk);
        check("x55_data", {22'd0, m2_valid, m2_last, m2_data},
              {22'd0, 1'b1, 1'b0, 8'h01});
        @(posedge clk); #1;
        @(negedge clk);
        check("x55_crc", {22'd0, m2_valid, m2_last, m2_data},
              {22'd0, 1'b1, 1'b1, 8'h52});
        @(posedge clk); #1;

        // frame_count wrap from 0xFFFF
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        check("wrap_pre", {16'd0, frame_count}, 32'h0000FFFF);
        @(posedge clk); #1;
        send_byte(8'h01, 1'b1);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h07});
        expect_beats("wrap");
        check("wrap_fc", {16'd0, frame_count}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_stream_appender.md
Name: crc8_stream_appender

Overview:
- Sequential streaming wrapper around the CRC-8/CCITT byte-update function: polynomial 0x07, MSB-first, no reflection.
- Accepts a byte stream framed by valid/ready/last and passes every data byte through a one-entry output register.
- After each frame's last byte, emits the frame's CRC byte as the new last beat.
- Sits directly upstream of the transmit path and drives the combinational byte-CRC stage's crcIn from its running CRC register.

Parameters:
- INIT, 8'h00, CRC register value at reset and at the start of every frame.
- XOR_OUT, 8'h00, value XORed into the CRC before it is emitted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream byte valid.
- s_ready  output  1  block can accept a byte this cycle.
- s_data  input  8  upstream byte.
- s_last  input  1  byte is the final data byte of its frame.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  8  data byte or appended CRC byte.
- m_last  output  1  beat is the CRC byte; marks end of the extended frame.
- abort  input  1  synchronous pulse: drop the in-progress frame's CRC state.
- crc_value  output  8  running CRC register (debug / status).
- frame_count  output  16  frames completed (CRC beat accepted downstream); wraps 0xFFFF to 0x0000.

Behaviour:
- Byte update, identical to the combinational stage: d = crc ^ byte; next[0]=d0^d6^d7, next[1]=d0^d1^d6, next[2]=d0^d1^d2^d6, next[3]=d1^d2^d3^d7, next[4]=d2^d3^d4, next[5]=d3^d4^d5, next[6]=d4^d5^d6, next[7]=d5^d6^d7.
- Reset (async assert): state=PASS, crc=INIT, m_valid=0, m_data=0, m_last=0, frame_count=0. Deassertion is used synchronously.
- Output slot free: slot_free = !m_valid || m_ready.
- Handshakes: s_ready = (state==PASS) && slot_free && !abort. An input fire is s_valid && s_ready. An output fire is m_valid && m_ready.
- PASS state, on input fire:
  - m_data<=s_data, m_last<=0, m_valid<=1.
  - crc<=next(crc, s_data).
  - If s_last, go to APPEND.
- PASS state, output fire with no input fire: m_valid<=0.
- APPEND state: s_ready=0. When slot_free:
  - m_data<=next-state crc ^ XOR_OUT (crc already includes the last byte), m_last<=1, m_valid<=1.
  - crc<=INIT, go to PASS.
- frame_count increments on the output fire of a beat with m_last=1.
- Latency: a data byte appears on m_data the cycle after its input fire. The CRC beat is presented the cycle after the last data byte leaves the slot, or the same cycle it leaves if m_ready is held.
- Throughput: with m_ready held high, an N-byte frame takes N+1 output cycles. s_ready is low for exactly 1 cycle between frames.
- m_data/m_last stay stable while m_valid && !m_ready (AXI-stream hold rule). s_data is ignored when there is no input fire.
- Abort:
  - Sets crc<=INIT and state<=PASS.
  - The beat already in the output register is kept and completes normally, so a frame can end without a CRC beat.
  - An abort in APPEND before the CRC is loaded suppresses that CRC beat.
  - Abort takes priority over a simultaneous input fire (s_ready is forced low).
- A single-byte frame (first byte also has s_last) is legal: 1 data beat + 1 CRC beat.
- Reset mid-frame: all state is cleared immediately. The partial frame's CRC is never emitted and m_valid drops asynchronously.
- s_last without a preceding byte cannot occur; s_last is only sampled on an input fire.

Test Plan:
- ASCII "123456789" (0x31..0x39, s_last on 0x39), m_ready=1, INIT=0, XOR_OUT=0 -> m_data 0x31..0x39 with m_last=0, then 0xF4 with m_last=1. Total 10 beats, frame_count=1.
- Single-byte frames 0x01, then 0xFF, back-to-back -> beats 0x01, 0x07(last), 0xFF, 0xF3(last). s_ready low exactly one cycle after each s_last fire. crc_value returns to 0x00.
- Same "123456789" frame with m_ready toggled 1,0,0,1 repeating -> identical beat sequence; m_data/m_last held stable during every stall; no byte lost or duplicated.
- abort pulsed after 0x31,0x32 accepted, then frame "1" (0x31, last) -> 0x31, 0x32 output without a CRC beat, then 0x31, 0x97(last). frame_count=1.
- rst asserted mid-frame while m_valid=1 and m_ready=0 -> m_valid=0 immediately, crc_value=0x00, frame_count=0. The next frame 0x01(last) yields 0x01, 0x07.
- XOR_OUT=8'h55, frame 0x01(last) -> CRC beat 0x52. frame_count wraps from 0xFFFF to 0x0000 after one more completed frame (preload by forcing, or run 65536 single-byte frames).
